// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - arbitrates I/D cache fill FSMs onto one pipelined memory port
// Round-robin ownership with a one-cycle turnaround; read beats are routed back by a tagged delay line.
module mem_fill_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_vld,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_vld,
  output logic [DATA_W-1:0] d_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_vld
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, TURN} state_t;

  state_t               state, state_nxt;
  logic                 last_d;
  logic [MEM_LAT-1:0]   pipe_vld;
  logic [MEM_LAT-1:0]   pipe_own;
  logic                 drop_seen;
  logic                 ret_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == OWN_I && !i_req) last_d <= 1'b0;
      if (state == OWN_D && !d_req) last_d <= 1'b1;
    end
  end

  // TURN blanks the bus for one cycle but otherwise arbitrates exactly like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, TURN: begin
        if (i_req && d_req) state_nxt = last_d ? OWN_I : OWN_D;
        else if (i_req)     state_nxt = OWN_I;
        else if (d_req)     state_nxt = OWN_D;
        else                state_nxt = IDLE;
      end
      OWN_I:   if (!i_req) state_nxt = TURN;
      OWN_D:   if (!d_req) state_nxt = TURN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_grant   = 1'b0;
    d_grant   = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      OWN_I: begin
        i_grant  = 1'b1;
        mem_en   = i_req;
        mem_addr = i_addr;
      end
      OWN_D: begin
        d_grant   = 1'b1;
        mem_en    = d_req;
        mem_wr    = d_req & d_wr;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Each read enters with its owner tag; the tag at the tail lines up with mem_data_vld.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld  <= '0;
      pipe_own  <= '0;
      drop_seen <= 1'b0;
    end else begin
      pipe_vld[0] <= mem_en & ~mem_wr;
      pipe_own[0] <= (state == OWN_D);
      for (int k = 1; k < MEM_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_own[k] <= pipe_own[k-1];
      end
      drop_seen <= drop_seen | (mem_data_vld & ~pipe_vld[MEM_LAT-1]);
    end
  end

  assign ret_vld    = mem_data_vld & pipe_vld[MEM_LAT-1];
  assign i_data_vld = ret_vld & ~pipe_own[MEM_LAT-1];
  assign d_data_vld = ret_vld &  pipe_own[MEM_LAT-1];
  assign i_data     = i_data_vld ? mem_rdata : '0;
  assign d_data     = d_data_vld ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - self-checking bench for mem_fill_arbiter
// Behavioural ownership/return model plus directed fills and a randomized phase.
module tb_mem_fill_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_grant, i_data_vld, d_grant, d_data_vld;
  logic [DW-1:0] i_data, d_data;
  logic          mem_en, mem_wr, mem_data_vld;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_vld(i_data_vld), .i_data(i_data),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data_vld(d_data_vld), .d_data(d_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_vld(mem_data_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return a ^ 16'hA55A;
  endfunction

  // Memory is not reset, so beats issued before a reset still come back afterwards.
  logic [LAT-1:0] mp_vld = '0;
  logic [DW-1:0]  mp_data [LAT];
  always @(posedge clk) begin
    mp_vld     <= {mp_vld[LAT-2:0], mem_en & ~mem_wr};
    mp_data[0] <= mdata(mem_addr);
    for (int k = 1; k < LAT; k++) mp_data[k] <= mp_data[k-1];
  end
  assign mem_data_vld = mp_vld[LAT-1];
  assign mem_rdata    = mp_data[LAT-1];

  typedef struct {int due; int own; logic [DW-1:0] data;} ret_t;
  ret_t rq[$];
  int   cur = 0, last = 1, cyc = 0;
  int   n_chk = 0, n_pass = 0;

  int            i_left = 0, d_left = 0, i_rounds = 0, d_rounds = 0;
  logic [AW-1:0] i_a = '0, d_a = '0;
  logic [DW-1:0] d_wd = '0;
  bit            d_w = 0, rnd = 0;

  int            i_vld_cnt, d_vld_cnt, i_first_iss, i_first_vld, d_fall, i_rise, overlap;
  logic [AW-1:0] i_iss_log[$];
  int            grant_log[$];
  bit            wr_seen, prev_ig, prev_dg;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({i_grant, d_grant, mem_en, mem_wr, i_data_vld, d_data_vld}), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_i_data"}, 32'(i_data), 0);
    chk({tag, "_d_data"}, 32'(d_data), 0);
  endtask

  task automatic clear_obs();
    i_vld_cnt = 0; d_vld_cnt = 0; i_first_iss = -1; i_first_vld = -1;
    d_fall = -1; i_rise = -1; overlap = 0; wr_seen = 0;
    i_iss_log.delete(); grant_log.delete();
  endtask

  task automatic tick();
    logic e_ig, e_dg, e_en, e_wr, e_iv, e_dv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd;
    ret_t r;
    @(negedge clk);
    if (!rst) begin
      check_zero("reset_outputs");
      cur = 0; last = 1; rq.delete(); prev_ig = 0; prev_dg = 0;
    end else begin
      e_ig   = (cur == 1);
      e_dg   = (cur == 2);
      e_en   = (e_ig && i_req) || (e_dg && d_req);
      e_wr   = e_dg && d_req && d_wr;
      e_addr = e_ig ? i_addr : d_addr;
      chk("i_grant", 32'(i_grant), 32'(e_ig));
      chk("d_grant", 32'(d_grant), 32'(e_dg));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      end
      if (e_wr) chk("mem_wdata", 32'(mem_wdata), 32'(d_wdata));
      e_iv = 0; e_dv = 0; e_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].own == 1) e_iv = 1; else e_dv = 1;
        e_rd = rq[0].data;
        void'(rq.pop_front());
      end
      chk("i_data_vld", 32'(i_data_vld), 32'(e_iv));
      chk("d_data_vld", 32'(d_data_vld), 32'(e_dv));
      chk("i_data", 32'(i_data), 32'(e_iv ? e_rd : '0));
      chk("d_data", 32'(d_data), 32'(e_dv ? e_rd : '0));
      if (e_en && !e_wr) begin
        r.due = cyc + LAT; r.own = cur; r.data = mdata(e_addr);
        rq.push_back(r);
      end
      if (i_data_vld) i_vld_cnt++;
      if (d_data_vld) d_vld_cnt++;
      if (mem_en && i_grant) begin
        i_iss_log.push_back(mem_addr);
        if (i_first_iss < 0) i_first_iss = cyc;
      end
      if (i_data_vld && i_first_vld < 0) i_first_vld = cyc;
      if (mem_en && mem_wr) begin wr_seen = 1; wr_a = mem_addr; wr_d = mem_wdata; end
      if (d_grant && !d_req) d_fall = cyc;
      if (i_grant && !prev_ig) begin i_rise = cyc; grant_log.push_back(1); end
      if (d_grant && !prev_dg) grant_log.push_back(2);
      if (d_data_vld && i_grant && mem_en) overlap++;
      prev_ig = i_grant; prev_dg = d_grant;
      // ownership rules: owner keeps bus while requesting, then alternates when both want it
      if (cur == 1 && !i_req) begin last = 1; cur = 0; end
      else if (cur == 2 && !d_req) begin last = 2; cur = 0; end
      else if (cur == 0) begin
        if (i_req && d_req) cur = (last == 1) ? 2 : 1;
        else if (i_req)     cur = 1;
        else if (d_req)     cur = 2;
        else                cur = 0;
      end
    end
    if (rst && i_req && i_grant) begin
      i_left--;
      i_a = rnd ? AW'($urandom) : i_a + 16'd2;
    end
    if (rst && d_req && d_grant) begin
      d_left--;
      d_a = rnd ? AW'($urandom) : d_a + 16'd2;
      if (rnd) d_wd = DW'($urandom);
      if (d_left == 0) d_w = 0;
    end
    if (i_left == 0 && !i_req && i_rounds > 0) begin i_rounds--; i_left = 4; end
    if (d_left == 0 && !d_req && d_rounds > 0) begin d_rounds--; d_left = 4; end
    @(posedge clk);
    cyc++;
    #1;
    i_req   = (i_left > 0);
    i_addr  = i_a;
    d_req   = (d_left > 0);
    d_wr    = d_w && (d_left > 0);
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k = 0;
    while (!(i_left == 0 && d_left == 0 && i_rounds == 0 && d_rounds == 0 &&
             !i_req && !d_req && rq.size() == 0 && cur == 0) && k < maxc) begin
      tick();
      k++;
    end
    tick();
    chk({"idle_", nm}, 32'(k < maxc), 1);
  endtask

  task automatic reset_pulse();
    #1 rst = 1'b0;
    #1 check_zero("async_reset_now");
    i_left = 0; d_left = 0; d_w = 0; i_rounds = 0; d_rounds = 0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int k;
    clear_obs();
    #1 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("drop_seen_reset", 32'(dut.drop_seen), 0);

    // single I fill of 8 beats
    clear_obs();
    i_a = 16'h1230; i_left = 8;
    wait_idle(60, "t1");
    chk("t1_issues", i_iss_log.size(), 8);
    for (int j = 0; j < 8 && j < i_iss_log.size(); j++)
      chk("t1_addr", 32'(i_iss_log[j]), 32'h1230 + 32'(2 * j));
    chk("t1_i_vld_cnt", i_vld_cnt, 8);
    chk("t1_d_vld_cnt", d_vld_cnt, 0);
    chk("t1_latency", i_first_vld - i_first_iss, LAT);

    // simultaneous requests right after reset: D first
    reset_pulse();
    clear_obs();
    i_a = 16'h0100; d_a = 16'h0800; i_left = 4; d_left = 4;
    wait_idle(60, "t2");
    chk("t2_first_grant_d", grant_log.size() > 0 ? grant_log[0] : 0, 2);
    chk("t2_i_grant_after_turn", i_rise - d_fall, 2);

    // D fill ends while I already waits
    clear_obs();
    d_a = 16'h0900; d_left = 8;
    k = 0;
    while (!prev_dg && k < 20) begin tick(); k++; end
    chk("t3_d_granted", 32'(prev_dg), 1);
    i_a = 16'h0A00; i_left = 8;
    wait_idle(80, "t3");
    chk("t3_i_grant_after_turn", i_rise - d_fall, 2);
    chk("t3_overlap", overlap, LAT - 2);
    chk("t3_d_vld_cnt", d_vld_cnt, 8);

    // single D write
    clear_obs();
    d_a = 16'h4000; d_wd = 16'hBEEF; d_w = 1; d_left = 1;
    for (int j = 0; j < 12; j++) tick();
    chk("t4_wr_seen", 32'(wr_seen), 1);
    chk("t4_wr_addr", 32'(wr_a), 32'h4000);
    chk("t4_wr_data", 32'(wr_d), 32'hBEEF);
    chk("t4_no_vld", i_vld_cnt + d_vld_cnt, 0);

    // back-to-back alternating fills
    clear_obs();
    i_a = 16'h1000; d_a = 16'h2000; i_left = 4; d_left = 4; i_rounds = 3; d_rounds = 3;
    wait_idle(200, "t5");
    chk("t5_grant_count", grant_log.size(), 8);
    for (int j = 1; j < grant_log.size(); j++)
      chk("t5_alternate", grant_log[j], grant_log[j-1] == 1 ? 2 : 1);
    chk("t5_i_vld_cnt", i_vld_cnt, 16);
    chk("t5_d_vld_cnt", d_vld_cnt, 16);

    // reset with 3 I beats in flight
    clear_obs();
    i_a = 16'h3000; i_left = 8;
    k = 0;
    while (i_iss_log.size() < 3 && k < 30) begin tick(); k++; end
    chk("t6_three_issued", i_iss_log.size(), 3);
    reset_pulse();
    clear_obs();
    for (int j = 0; j < 10; j++) tick();
    chk("t6_no_i_vld", i_vld_cnt, 0);
    chk("t6_drop_seen", 32'(dut.drop_seen), 1);

    // randomized traffic
    reset_pulse();
    rnd = 1;
    for (int j = 0; j < 1500; j++) begin
      if (i_left == 0 && !i_req && $urandom_range(0, 3) == 0) begin
        i_a = AW'($urandom); i_left = $urandom_range(1, 8);
      end
      if (d_left == 0 && !d_req && $urandom_range(0, 3) == 0) begin
        d_a = AW'($urandom); d_wd = DW'($urandom);
        if ($urandom_range(0, 2) == 0) begin d_w = 1; d_left = 1; end
        else begin d_w = 0; d_left = $urandom_range(1, 8); end
      end
      tick();
    end
    wait_idle(100, "rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
